// File: rtl/mem_arbiter_if.sv
// Bundle of the refill, data-access and external-memory signals around mem_arbiter.
// The arbiter uses the master modport; the surrounding core/RAM side uses slave.
interface mem_arbiter_if #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4
) ();
    // I-cache refill path
    logic                         i_req;
    logic [ADDR_W-1:0]            i_addr;
    logic [LINE_WORDS*DATA_W-1:0] i_line;
    logic                         i_done;

    // data-memory path
    logic                         d_req;
    logic                         d_we;
    logic [ADDR_W-1:0]            d_addr;
    logic [DATA_W-1:0]            d_wdata;
    logic [DATA_W-1:0]            d_rdata;
    logic                         d_done;

    // external memory port
    logic                         mem_req;
    logic                         mem_we;
    logic [ADDR_W-1:0]            mem_addr;
    logic [DATA_W-1:0]            mem_wdata;
    logic [DATA_W-1:0]            mem_rdata;
    logic                         mem_ack;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_line, i_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_line, i_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one external memory port between I-cache line refills
// and single-word data accesses. Define MEMARB_STARVE_GUARD_EN to add the starvation guard.
module mem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          nrst,
    mem_arbiter_if.master bus,
    output logic          busy
);
    localparam int KW = $clog2(LINE_WORDS);
    localparam int LB = KW + 2;
    localparam int LW = LINE_WORDS * DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        I_BURST,
        D_ACC,
        DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [KW-1:0]          k_next;
    logic [ADDR_W-LB-1:0]   base_q, base_d;

    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic [LW-1:0]          i_line_q, i_line_d;
    logic                   i_done_q, i_done_d;
    logic [DATA_W-1:0]      d_rdata_q, d_rdata_d;
    logic                   d_done_q, d_done_d;
    logic                   busy_q, busy_d;

    logic                   grant_d;
    logic                   grant_i;
    logic                   guard_trip;
    logic                   last_beat;

    // Data wins in IDLE unless the guard has tripped with a refill waiting.
    assign grant_d   = (state_q == IDLE) && bus.d_req && (!bus.i_req || !guard_trip);
    assign grant_i   = (state_q == IDLE) && bus.i_req && !grant_d;
    assign last_beat = (k_q == KW'(LINE_WORDS - 1));
    assign k_next    = k_q + 1'b1;

`ifdef MEMARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q, starve_d;

    assign guard_trip = (starve_q == SW'(STARVE_MAX));

    // A data grant with i_req high implies the guard is not tripped, so this saturates.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (!bus.i_req || grant_i) begin
                starve_d = '0;
            end else if (grant_d) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign guard_trip = 1'b0;
`endif

    // NOTE: every _d gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        base_d      = base_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_line_d    = i_line_q;
        i_done_d    = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = D_ACC;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                end else if (grant_i) begin
                    state_d    = I_BURST;
                    k_d        = '0;
                    base_d     = bus.i_addr[ADDR_W-1:LB];
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {bus.i_addr[ADDR_W-1:LB], {KW{1'b0}}, 2'b00};
                end
            end

            D_ACC: begin
                if (bus.mem_ack) begin
                    state_d  = DONE;
                    d_done_d = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    mem_req_d = 1'b1;
                end
            end

            I_BURST: begin
                mem_req_d = 1'b1;
                if (bus.mem_ack) begin
                    i_line_d[k_q*DATA_W +: DATA_W] = bus.mem_rdata;
                    if (last_beat) begin
                        state_d   = DONE;
                        i_done_d  = 1'b1;
                        mem_req_d = 1'b0;
                        k_d       = '0;
                    end else begin
                        k_d        = k_next;
                        mem_addr_d = {base_q, k_next, 2'b00};
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: state uses non-blocking assignments only; the reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            base_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_line_q    <= '0;
            i_done_q    <= 1'b0;
            d_rdata_q   <= '0;
            d_done_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            base_q      <= base_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_line_q    <= i_line_d;
            i_done_q    <= i_done_d;
            d_rdata_q   <= d_rdata_d;
            d_done_q    <= d_done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_line    = i_line_q;
    assign bus.i_done    = i_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_done    = d_done_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expected order under contention
// follows MEMARB_STARVE_GUARD_EN.
module tb_mem_arbiter;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int LINE_WORDS = 4;
    localparam int STARVE_MAX = 4;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    logic busy;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS)) bus ();

    mem_arbiter #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .LINE_WORDS(LINE_WORDS),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1ns after the active edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0]  w [4];
    logic [9:0]   seq;
    logic [9:0]   seq_exp;
    int           ev;

    initial begin
        bus.i_req     = 1'b1;
        bus.i_addr    = 32'h30;
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h10;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;

        // ---- reset held 3 cycles with both requests high
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_mem_req", bus.mem_req, 0);
            check("rst_busy", busy, 0);
            check("rst_dones", {bus.i_done, bus.d_done}, 0);
        end
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_i_line", bus.i_line, 0);
        check("rst_d_rdata", bus.d_rdata, 0);

        nrst          = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0BAD_F00D;
        tick();
        check("rel_mem_req", bus.mem_req, 1);
        check("rel_mem_addr_data", bus.mem_addr, 32'h10);
        check("rel_mem_we", bus.mem_we, 0);
        tick();
        check("rel_d_done", bus.d_done, 1);
        check("rel_i_done", bus.i_done, 0);
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
        tick();
        check("rel_idle", busy, 0);

        // ---- zero-wait load
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h100;
        bus.mem_rdata = 32'hDEAD_BEEF;
        bus.d_req     = 1'b1;
        tick();
        check("ld_mem_req", bus.mem_req, 1);
        check("ld_mem_addr", bus.mem_addr, 32'h100);
        check("ld_mem_we", bus.mem_we, 0);
        check("ld_early_done", bus.d_done, 0);
        tick();
        check("ld_d_done", bus.d_done, 1);
        check("ld_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        check("ld_done_no_req", bus.mem_req, 0);
        bus.d_req = 1'b0;
        tick();
        check("ld_pulse_len", bus.d_done, 0);
        check("ld_idle", busy, 0);

        // ---- refill with one wait cycle per beat, i_addr=0x2C
        for (int k = 0; k < 4; k++) w[k] = 32'hA000_0000 + 32'(k) * 32'h111;
        bus.i_addr = 32'h2C;
        bus.i_req  = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.mem_ack = 1'b0;
            check("rf_mem_req", bus.mem_req, 1);
            check("rf_addr", bus.mem_addr, 32'h20 + 32'(4 * k));
            check("rf_no_done", bus.i_done, 0);
            tick();
            check("rf_addr_hold", bus.mem_addr, 32'h20 + 32'(4 * k));
            check("rf_we", bus.mem_we, 0);
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = w[k];
            tick();
        end
        check("rf_i_done_c9", bus.i_done, 1);
        check("rf_i_line", bus.i_line, {w[3], w[2], w[1], w[0]});
        check("rf_done_no_req", bus.mem_req, 0);
        bus.i_req = 1'b0;
        tick();
        check("rf_pulse_len", bus.i_done, 0);
        check("rf_idle", busy, 0);

        // ---- store 0x55 to 0x40, then load it back
        bus.d_we      = 1'b1;
        bus.d_addr    = 32'h40;
        bus.d_wdata   = 32'h55;
        bus.d_req     = 1'b1;
        tick();
        check("st_mem_we", bus.mem_we, 1);
        check("st_mem_addr", bus.mem_addr, 32'h40);
        check("st_mem_wdata", bus.mem_wdata, 32'h55);
        bus.mem_rdata = 32'h1234_5678;
        tick();
        check("st_d_done", bus.d_done, 1);
        check("st_rdata_kept", bus.d_rdata, 32'hDEAD_BEEF);
        bus.d_we = 1'b0;
        tick();
        check("b2b_idle_gap", busy, 0);
        check("b2b_gap_no_req", bus.mem_req, 0);
        bus.mem_rdata = 32'h55;
        tick();
        check("ld2_mem_req", bus.mem_req, 1);
        check("ld2_mem_we", bus.mem_we, 0);
        check("ld2_mem_addr", bus.mem_addr, 32'h40);
        tick();
        check("ld2_d_done", bus.d_done, 1);
        check("ld2_d_rdata", bus.d_rdata, 32'h55);
        bus.d_req = 1'b0;
        tick();

        // ---- contention: both requests held high
`ifdef MEMARB_STARVE_GUARD_EN
        seq_exp = 10'b10_0001_0000;
`else
        seq_exp = 10'b00_0000_0000;
`endif
        bus.d_addr  = 32'h80;
        bus.i_addr  = 32'h200;
        bus.mem_ack = 1'b1;
        bus.d_req   = 1'b1;
        bus.i_req   = 1'b1;
        seq = '0;
        ev  = 0;
        for (int c = 0; c < 200 && ev < 10; c++) begin
            tick();
            if (bus.d_done || bus.i_done) begin
                seq[ev] = bus.i_done;
                ev++;
            end
        end
        check("cont_events", ev, 10);
        check("cont_order", seq, seq_exp);
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
        tick();
        check("cont_idle", busy, 0);

        // ---- reset during beat 2 of a burst, then a clean refill
        bus.i_addr    = 32'h104;
        bus.mem_rdata = 32'h1111_1111;
        bus.i_req     = 1'b1;
        tick();
        check("mr_beat0", bus.mem_addr, 32'h100);
        tick();
        check("mr_beat1", bus.mem_addr, 32'h104);
        tick();
        check("mr_beat2", bus.mem_addr, 32'h108);
        nrst = 1'b0;
        tick();
        check("mr_no_req", bus.mem_req, 0);
        check("mr_no_done", bus.i_done, 0);
        check("mr_busy", busy, 0);
        check("mr_line_clr", bus.i_line, 0);
        nrst = 1'b1;
        for (int k = 0; k < 4; k++) w[k] = 32'h5000_0000 | 32'(k + 1);
        tick();
        check("mr_restart_req", bus.mem_req, 1);
        check("mr_restart_beat0", bus.mem_addr, 32'h100);
        for (int k = 0; k < 4; k++) begin
            check("mr_rf_no_done", bus.i_done, 0);
            bus.mem_rdata = w[k];
            tick();
        end
        check("mr_i_done", bus.i_done, 1);
        check("mr_i_line", bus.i_line, {w[3], w[2], w[1], w[0]});
        bus.i_req = 1'b0;
        tick();
        check("mr_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
